// File: rtl/rat_intr_pkg.sv
// rtl/rat_intr_pkg.sv - shared types and constants for the interrupt controller
package rat_intr_pkg;

  localparam int NUM_SRC = 8;

  // Register offsets relative to BASE_PORT
  localparam logic [7:0] MASK_OFS = 8'd0;
  localparam logic [7:0] PEND_OFS = 8'd1;
  localparam logic [7:0] ID_OFS   = 8'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/rat_intr_ctrl_if.sv
// rtl/rat_intr_ctrl_if.sv - CPU I/O bus and interrupt handshake bundle
interface rat_intr_ctrl_if;

  logic [7:0] irq;
  logic       io_strb;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_data;
  logic       in_hit;
  logic       intr_ack;
  logic       intr_eoi;
  logic       interrupt;
  logic [2:0] active_id;
  logic       in_service;

  modport slave (
    input  irq, io_strb, port_id, out_port, intr_ack, intr_eoi,
    output in_data, in_hit, interrupt, active_id, in_service
  );

  modport master (
    output irq, io_strb, port_id, out_port, intr_ack, intr_eoi,
    input  in_data, in_hit, interrupt, active_id, in_service
  );

endinterface

// File: rtl/rat_prio_enc8.sv
// rtl/rat_prio_enc8.sv - 8-bit priority encoder, lowest set index wins
module rat_prio_enc8 (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan downward so the lowest set bit is the last assignment
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// rtl/rat_intr_ctrl.sv - edge-triggered, maskable, non-nesting interrupt controller
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'hF0
) (
  input  logic           clk,
  input  logic           reset_n,
  rat_intr_ctrl_if.slave bus
);

  localparam logic [7:0] MASK_PORT = BASE_PORT + MASK_OFS;
  localparam logic [7:0] PEND_PORT = BASE_PORT + PEND_OFS;
  localparam logic [7:0] ID_PORT   = BASE_PORT + ID_OFS;

  state_t state, state_nxt;

  logic [NUM_SRC-1:0] mask, pending, prev;
  logic [NUM_SRC-1:0] edges, eligible, clr, ack_bit;
  logic [2:0]         active_id, win_idx;
  logic               win_valid, wr_mask, wr_pend, ack_take;

  rat_prio_enc8 u_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign edges    = bus.irq & ~prev;
  assign eligible = pending & mask;
  assign wr_mask  = bus.io_strb && (bus.port_id == MASK_PORT);
  assign wr_pend  = bus.io_strb && (bus.port_id == PEND_PORT);
  assign ack_take = (state == REQ) && bus.intr_ack && win_valid;
  assign ack_bit  = 8'(1) << win_idx;
  assign clr      = (wr_pend ? bus.out_port : 8'h00) | (ack_take ? ack_bit : 8'h00);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = REQ;
      REQ: begin
        if (!win_valid)        state_nxt = IDLE;
        else if (bus.intr_ack) state_nxt = SERVICE;
      end
      SERVICE: if (bus.intr_eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.interrupt  = (state == REQ);
    bus.in_service = (state == SERVICE);
  end

  // A new edge overrides any clear landing on the same bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask      <= '0;
      pending   <= '0;
      active_id <= 3'd0;
      prev      <= bus.irq;
    end else begin
      prev    <= bus.irq;
      pending <= (pending & ~clr) | edges;
      if (wr_mask)  mask      <= bus.out_port;
      if (ack_take) active_id <= win_idx;
    end
  end

  assign bus.active_id = active_id;

  always_comb begin
    bus.in_hit  = 1'b0;
    bus.in_data = 8'h00;
    if (bus.port_id == MASK_PORT) begin
      bus.in_hit  = 1'b1;
      bus.in_data = mask;
    end else if (bus.port_id == PEND_PORT) begin
      bus.in_hit  = 1'b1;
      bus.in_data = pending;
    end else if (bus.port_id == ID_PORT) begin
      bus.in_hit  = 1'b1;
      bus.in_data = {bus.in_service, 4'b0000, active_id};
    end
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// tb/tb_rat_intr_ctrl.sv - directed and randomized checks of rat_intr_ctrl against a reference model
module tb_rat_intr_ctrl;

  localparam logic [7:0] BASE = 8'hF0;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] m_mask, m_pend, m_prev;
  logic [2:0] m_id;
  bit         m_req, m_svc;

  rat_intr_ctrl_if bus ();

  rat_intr_ctrl #(.BASE_PORT(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] p);
    if (p == BASE)        return m_mask;
    if (p == BASE + 8'd1) return m_pend;
    if (p == BASE + 8'd2) return {m_svc, 4'b0000, m_id};
    return 8'h00;
  endfunction

  function automatic logic model_hit(input logic [7:0] p);
    return (p >= BASE) && (p <= BASE + 8'd2);
  endfunction

  // One clock edge of the controller's behaviour, from the inputs currently applied
  task automatic model_step();
    logic [7:0] elig, clr, rises;
    int w;
    rises = bus.irq & ~m_prev;
    elig  = m_pend & m_mask;
    w = 0;
    for (int i = 7; i >= 0; i--) if (elig[i]) w = i;
    if (!reset_n) begin
      m_mask = 8'h00; m_pend = 8'h00; m_id = 3'd0;
      m_req = 0; m_svc = 0; m_prev = bus.irq;
      return;
    end
    clr = (bus.io_strb && bus.port_id == BASE + 8'd1) ? bus.out_port : 8'h00;
    if (m_req) begin
      if (elig == 8'h00) m_req = 0;
      else if (bus.intr_ack) begin
        clr = clr | (8'h01 << w);
        m_id = 3'(w);
        m_req = 0;
        m_svc = 1;
      end
    end else if (m_svc) begin
      if (bus.intr_eoi) m_svc = 0;
    end else if (elig != 8'h00) begin
      m_req = 1;
    end
    if (bus.io_strb && bus.port_id == BASE) m_mask = bus.out_port;
    m_pend = (m_pend & ~clr) | rises;
    m_prev = bus.irq;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("interrupt",  bus.interrupt,  m_req);
    chk("in_service", bus.in_service, m_svc);
    chk("active_id",  bus.active_id,  m_id);
    chk("in_hit",     bus.in_hit,     model_hit(bus.port_id));
    chk("in_data",    bus.in_data,    model_read(bus.port_id));
    bus.io_strb  = 1'b0;
    bus.intr_ack = 1'b0;
    bus.intr_eoi = 1'b0;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    bus.io_strb  = 1'b1;
    bus.port_id  = p;
    bus.out_port = d;
    cycle();
  endtask

  initial begin
    int r;
    m_mask = 8'h00; m_pend = 8'h00; m_prev = 8'h00; m_id = 3'd0; m_req = 0; m_svc = 0;
    reset_n = 1'b0;
    bus.irq = 8'h00; bus.io_strb = 1'b0; bus.port_id = BASE; bus.out_port = 8'h00;
    bus.intr_ack = 1'b0; bus.intr_eoi = 1'b0;
    cycle();
    cycle();
    chk("rst_interrupt",  bus.interrupt,  8'h00);
    chk("rst_in_service", bus.in_service, 8'h00);
    chk("rst_active_id",  bus.active_id,  8'h00);
    chk("rst_mask",       bus.in_data,    8'h00);
    reset_n = 1'b1;

    // Single unmasked source: latency and acknowledge
    wr(BASE, 8'h04);
    bus.irq = 8'h04; bus.port_id = BASE + 8'd1;
    cycle();
    chk("s35_pend", bus.in_data, 8'h04);
    chk("s35_int_early", bus.interrupt, 8'h00);
    cycle();
    chk("s35_int", bus.interrupt, 8'h01);
    bus.intr_ack = 1'b1;
    cycle();
    chk("s35_id", bus.active_id, 8'h02);
    chk("s35_pend_clr", bus.in_data, 8'h00);
    chk("s35_svc", bus.in_service, 8'h01);
    bus.intr_eoi = 1'b1;
    cycle();
    bus.irq = 8'h00;
    cycle();

    // Two simultaneous sources: priority and re-raise after EOI
    wr(BASE, 8'hFF);
    bus.irq = 8'h28;
    cycle();
    cycle();
    bus.intr_ack = 1'b1;
    cycle();
    chk("s36_id_first", bus.active_id, 8'h03);
    bus.intr_eoi = 1'b1;
    cycle();
    chk("s36_int_idle", bus.interrupt, 8'h00);
    cycle();
    chk("s36_int_again", bus.interrupt, 8'h01);
    bus.intr_ack = 1'b1;
    cycle();
    chk("s36_id_second", bus.active_id, 8'h05);
    bus.intr_eoi = 1'b1;
    cycle();
    bus.irq = 8'h00;
    cycle();

    // Masked source stays pending, unmasking raises the request
    wr(BASE, 8'h00);
    bus.irq = 8'h02; bus.port_id = BASE + 8'd1;
    cycle();
    chk("s37_pend", bus.in_data, 8'h02);
    cycle();
    cycle();
    chk("s37_int_masked", bus.interrupt, 8'h00);
    wr(BASE, 8'h02);
    chk("s37_int_1", bus.interrupt, 8'h00);
    cycle();
    chk("s37_int_2", bus.interrupt, 8'h01);
    wr(BASE + 8'd1, 8'h02);
    cycle();
    bus.irq = 8'h00;
    cycle();

    // Withdrawal by W1C while requesting, late ACK ignored
    wr(BASE, 8'h01);
    bus.irq = 8'h01;
    cycle();
    cycle();
    chk("s38_int", bus.interrupt, 8'h01);
    wr(BASE + 8'd1, 8'h01);
    cycle();
    chk("s38_int_drop", bus.interrupt, 8'h00);
    bus.intr_ack = 1'b1;
    cycle();
    chk("s38_no_svc", bus.in_service, 8'h00);

    // Source held through reset produces no edge; set beats W1C
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1; bus.port_id = BASE + 8'd1;
    cycle();
    chk("s39_no_edge", bus.in_data, 8'h00);
    bus.irq = 8'h00;
    cycle();
    bus.irq = 8'h01;
    wr(BASE + 8'd1, 8'h01);
    chk("s39_set_wins", bus.in_data, 8'h01);
    bus.irq = 8'h00;
    wr(BASE + 8'd1, 8'hFF);

    // Reset while in service
    wr(BASE, 8'h40);
    bus.irq = 8'h40;
    cycle();
    cycle();
    bus.intr_ack = 1'b1;
    cycle();
    chk("s40_id", bus.active_id, 8'h06);
    reset_n = 1'b0; bus.port_id = BASE;
    cycle();
    chk("s40_svc", bus.in_service, 8'h00);
    chk("s40_id_rst", bus.active_id, 8'h00);
    chk("s40_mask", bus.in_data, 8'h00);
    reset_n = 1'b1; bus.irq = 8'h00;
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      bus.irq = bus.irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r = $urandom_range(0, 9);
      if (r < 5) bus.port_id = BASE + 8'($urandom_range(0, 3));
      else       bus.port_id = 8'($urandom);
      if (r < 3) begin
        bus.io_strb  = 1'b1;
        bus.out_port = 8'($urandom);
      end
      bus.intr_ack = ($urandom_range(0, 3) == 0);
      bus.intr_eoi = ($urandom_range(0, 4) == 0);
      reset_n      = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
